// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end for the 9-bit CPU.
// Owns the program counter and issues reads to a 1-cycle synchronous ROM.
// Returned words go into a 2-entry queue, which feeds decode over valid/ready.
// Redirects flush the queue and restart fetch at a new PC; halt parks the unit.
module instr_fetch_unit #(
   parameter int              PC_W     = 10,
   parameter logic [PC_W-1:0] START_PC = '0,
   parameter int              DEPTH    = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   output logic            imem_en,
   output logic [PC_W-1:0] imem_addr,
   input  logic [8:0]      imem_rdata,
   input  logic            redirect_en,
   input  logic [PC_W-1:0] redirect_pc,
   input  logic            halt_req,
   output logic            instr_valid,
   input  logic            instr_ready,
   output logic [8:0]      instr,
   output logic [4:0]      instr_op,
   output logic [3:0]      instr_arg,
   output logic [PC_W-1:0] instr_pc,
   output logic            busy,
   output logic            done
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] HALT = 2'd2;

   logic [1:0]      state;
   logic [PC_W-1:0] pc_q;
   logic [1:0]      count;
   logic            inflight;
   logic [PC_W-1:0] inflight_pc;
   logic [8:0]      q0_word, q1_word;
   logic [PC_W-1:0] q0_pc, q1_pc;

   logic            run, pop, flow, issue, push, pop_q, slot_hi;
   logic [2:0]      occ;

   assign run   = (state == RUN);
   assign pop   = instr_valid & instr_ready;
   // Normal fetch flow: redirect and halt both pre-empt issue, push and pop.
   assign flow  = run & ~redirect_en & ~halt_req;
   // Occupancy projected to the end of this cycle, counting the word still in the ROM.
   assign occ   = {1'b0, count} - {2'b0, pop} + {2'b0, inflight};
   assign issue = flow & (occ < 3'(DEPTH));
   assign push  = flow & inflight;
   assign pop_q = flow & pop;
   // A push lands in the upper slot when one entry survives this cycle's pop.
   assign slot_hi = (count == 2'd2) | ((count == 2'd1) & ~pop_q);

   assign imem_en     = issue;
   assign imem_addr   = pc_q;
   assign instr_valid = (count != 2'd0);
   assign instr       = instr_valid ? q0_word : 9'd0;
   assign instr_pc    = instr_valid ? q0_pc : '0;
   assign instr_op    = instr[8:4];
   assign instr_arg   = instr[3:0];
   assign busy        = run;
   assign done        = (state == HALT);

   // Control state: FSM, program counter, queue occupancy and in-flight flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         pc_q     <= START_PC;
         count    <= 2'd0;
         inflight <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               if (halt_req) begin
                  state    <= HALT;
                  count    <= 2'd0;
                  inflight <= 1'b0;
               end else if (redirect_en) begin
                  pc_q     <= redirect_pc;
                  count    <= 2'd0;
                  inflight <= 1'b0;
               end else begin
                  count    <= count - {1'b0, pop_q} + {1'b0, push};
                  inflight <= issue;
                  if (issue) begin
                     pc_q <= pc_q + PC_W'(1);
                  end
               end
            end
            default: begin
               if (start) begin
                  state    <= RUN;
                  pc_q     <= START_PC;
                  count    <= 2'd0;
                  inflight <= 1'b0;
               end
            end
         endcase
      end
   end

   // Queue payload and in-flight address; validity is carried by count/inflight.
   always_ff @(posedge clk) begin
      if (pop_q) begin
         q0_word <= q1_word;
         q0_pc   <= q1_pc;
      end
      if (push) begin
         if (slot_hi) begin
            q1_word <= imem_rdata;
            q1_pc   <= inflight_pc;
         end else begin
            q0_word <= imem_rdata;
            q0_pc   <= inflight_pc;
         end
      end
      if (issue) begin
         inflight_pc <= pc_q;
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: ROM model, stream scoreboard, directed and random phases.
`timescale 1ns/1ps
module tb_instr_fetch_unit;

   localparam int              PC_W     = 10;
   localparam logic [PC_W-1:0] START_PC = '0;

   logic            clk = 1'b0;
   logic            reset, start, imem_en, redirect_en, halt_req;
   logic            instr_valid, instr_ready, busy, done;
   logic [PC_W-1:0] imem_addr, redirect_pc, instr_pc;
   logic [8:0]      imem_rdata, instr;
   logic [4:0]      instr_op;
   logic [3:0]      instr_arg;

   int checks = 0;
   int failures = 0;

   logic [8:0]      rom [0:(1<<PC_W)-1];
   // Expected start address of each fetch stream, pushed by the driver.
   logic [PC_W-1:0] seg_q [$];
   logic            mdl_run = 1'b0;
   logic            mdl_halt = 1'b0;
   logic [PC_W-1:0] exp_pc = '0;
   logic            drv_run = 1'b0;

   always #5 clk = ~clk;

   instr_fetch_unit #(.PC_W(PC_W), .START_PC(START_PC), .DEPTH(2)) dut (
      .clk(clk), .reset(reset), .start(start),
      .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .redirect_en(redirect_en), .redirect_pc(redirect_pc), .halt_req(halt_req),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
      .instr_op(instr_op), .instr_arg(instr_arg), .instr_pc(instr_pc),
      .busy(busy), .done(done)
   );

   // Synchronous ROM with one cycle of read latency.
   always @(posedge clk) if (imem_en) imem_rdata <= rom[imem_addr];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      failures++;
      $display("FAIL %s t=%0t", name, $time);
   endtask

   // Monitor: every presented head must be the next word of the current stream.
   always @(negedge clk) begin
      if (reset) begin
         mdl_run  = 1'b0;
         mdl_halt = 1'b0;
      end else begin
         chk("busy", 32'(busy), 32'(mdl_run));
         chk("done", 32'(done), 32'(mdl_halt));
         if (!mdl_run) begin
            chk("idle_valid", 32'(instr_valid), 32'd0);
            chk("idle_imem_en", 32'(imem_en), 32'd0);
         end else if (instr_valid) begin
            chk("head_pc", 32'(instr_pc), 32'(exp_pc));
            chk("head_word", 32'(instr), 32'(rom[exp_pc]));
            chk("head_op", 32'(instr_op), 32'(rom[exp_pc][8:4]));
            chk("head_arg", 32'(instr_arg), 32'(rom[exp_pc][3:0]));
            if (instr_ready) exp_pc = exp_pc + PC_W'(1);
         end
         if (mdl_run) begin
            if (halt_req) begin
               mdl_run  = 1'b0;
               mdl_halt = 1'b1;
            end else if (redirect_en) begin
               if (seg_q.size() == 0) fail_now("scoreboard_empty_redirect");
               else exp_pc = seg_q.pop_front();
            end
         end else if (start) begin
            if (seg_q.size() == 0) fail_now("scoreboard_empty_start");
            else exp_pc = seg_q.pop_front();
            mdl_run  = 1'b1;
            mdl_halt = 1'b0;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_valid"}, 32'(instr_valid), 32'd0);
      chk({tag, "_imem_en"}, 32'(imem_en), 32'd0);
      chk({tag, "_imem_addr"}, 32'(imem_addr), 32'(START_PC));
      chk({tag, "_instr"}, 32'(instr), 32'd0);
      chk({tag, "_op_arg"}, 32'({instr_op, instr_arg}), 32'd0);
      chk({tag, "_instr_pc"}, 32'(instr_pc), 32'd0);
      chk({tag, "_busy_done"}, 32'({busy, done}), 32'd0);
   endtask

   // Start pulse with first-word latency checks; ends at the negedge after E2.
   task automatic start_and_check(input string tag);
      start = 1'b1;
      seg_q.push_back(START_PC);
      drv_run = 1'b1;
      step();
      start = 1'b0;
      @(negedge clk);
      chk({tag, "_en_after_e0"}, 32'(imem_en), 32'd1);
      chk({tag, "_addr_after_e0"}, 32'(imem_addr), 32'(START_PC));
      chk({tag, "_valid_after_e0"}, 32'(instr_valid), 32'd0);
      step();
      @(negedge clk);
      chk({tag, "_valid_after_e1"}, 32'(instr_valid), 32'd0);
      step();
      @(negedge clk);
      chk({tag, "_valid_after_e2"}, 32'(instr_valid), 32'd1);
      chk({tag, "_pc_after_e2"}, 32'(instr_pc), 32'(START_PC));
   endtask

   task automatic wait_addr(input logic [PC_W-1:0] a, input string tag);
      int n = 0;
      while (imem_addr !== a && n < 2000) begin
         step();
         n++;
      end
      if (n >= 2000) fail_now({tag, "_timeout"});
   endtask

   // Redirect sampled at edge R; first new word expected after R+2.
   task automatic redirect_and_check(input logic [PC_W-1:0] tgt, input string tag);
      redirect_en = 1'b1;
      redirect_pc = tgt;
      seg_q.push_back(tgt);
      step();
      redirect_en = 1'b0;
      @(negedge clk);
      chk({tag, "_valid_after_r"}, 32'(instr_valid), 32'd0);
      step();
      @(negedge clk);
      chk({tag, "_valid_after_r1"}, 32'(instr_valid), 32'd0);
      step();
      @(negedge clk);
      chk({tag, "_valid_after_r2"}, 32'(instr_valid), 32'd1);
      chk({tag, "_pc_after_r2"}, 32'(instr_pc), 32'(tgt));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [PC_W-1:0] head_pc;
      logic [PC_W-1:0] want;
      int r;
      for (int i = 0; i < (1 << PC_W); i++) rom[i] = 9'($urandom_range(0, 511));
      reset = 1'b1; start = 1'b0; redirect_en = 1'b0; redirect_pc = '0;
      halt_req = 1'b0; instr_ready = 1'b1;
      #2;
      check_reset_outputs("reset_init");
      repeat (3) step();
      reset = 1'b0;
      step();

      // Fetch from START_PC, one word per cycle.
      start_and_check("start1");
      for (int i = 1; i < 8; i++) begin
         step();
         @(negedge clk);
         chk("steady_valid", 32'(instr_valid), 32'd1);
         chk("steady_pc", 32'(instr_pc), 32'(START_PC + PC_W'(i)));
      end

      // Halt at pc 0x010, then restart.
      wait_addr(10'h010, "halt_wait");
      halt_req = 1'b1;
      drv_run = 1'b0;
      step();
      halt_req = 1'b0;
      @(negedge clk);
      chk("halt_done", 32'(done), 32'd1);
      chk("halt_busy", 32'(busy), 32'd0);
      chk("halt_valid", 32'(instr_valid), 32'd0);
      chk("halt_imem_en", 32'(imem_en), 32'd0);
      repeat (2) step();
      start_and_check("restart");

      // Redirect to 0x040 while pc_q=0x005 with a read in flight.
      wait_addr(10'h005, "redir_wait");
      redirect_and_check(10'h040, "redir40");

      // Decode stalls for 3 cycles: head held, no fetch issued.
      repeat (3) step();
      instr_ready = 1'b0;
      @(negedge clk);
      head_pc = instr_pc;
      for (int i = 0; i < 3; i++) begin
         chk("stall_imem_en", 32'(imem_en), 32'd0);
         chk("stall_head_pc", 32'(instr_pc), 32'(head_pc));
         step();
         @(negedge clk);
      end
      step();
      instr_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("resume_valid", 32'(instr_valid), 32'd1);
         chk("resume_pc", 32'(instr_pc), 32'(head_pc + PC_W'(i)));
         step();
      end

      // PC wraps through the top of the address space.
      redirect_and_check(10'h3FE, "wrap");
      want = 10'h3FE;
      for (int i = 1; i < 4; i++) begin
         step();
         @(negedge clk);
         want = want + PC_W'(1);
         chk("wrap_pc", 32'(instr_pc), 32'(want));
      end

      // Randomized traffic; stray controls outside RUN must be ignored.
      step();
      for (int c = 0; c < 400; c++) begin
         instr_ready = ($urandom_range(0, 9) < 7);
         redirect_en = 1'b0; halt_req = 1'b0; start = 1'b0;
         r = $urandom_range(0, 99);
         if (drv_run) begin
            if (r < 2) begin
               halt_req = 1'b1;
               drv_run = 1'b0;
            end else if (r < 7) begin
               redirect_en = 1'b1;
               redirect_pc = PC_W'($urandom);
               seg_q.push_back(redirect_pc);
            end else if (r < 9) begin
               start = 1'b1;
            end
         end else begin
            if (r < 25) begin
               start = 1'b1;
               seg_q.push_back(START_PC);
               drv_run = 1'b1;
            end else if (r < 40) begin
               redirect_en = 1'b1;
               redirect_pc = PC_W'($urandom);
            end else if (r < 50) begin
               halt_req = 1'b1;
            end
         end
         step();
      end
      redirect_en = 1'b0; halt_req = 1'b0; start = 1'b0; instr_ready = 1'b1;

      // Asynchronous reset with the queue full.
      if (!drv_run) begin
         start = 1'b1;
         seg_q.push_back(START_PC);
         drv_run = 1'b1;
         step();
         start = 1'b0;
      end
      repeat (5) step();
      instr_ready = 1'b0;
      repeat (3) step();
      @(negedge clk);
      chk("prereset_valid", 32'(instr_valid), 32'd1);
      @(posedge clk);
      #3;
      reset = 1'b1;
      drv_run = 1'b0;
      seg_q.delete();
      #1;
      check_reset_outputs("reset_mid");
      repeat (2) step();
      reset = 1'b0;
      instr_ready = 1'b1;
      step();
      start_and_check("post_reset");
      repeat (6) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
